// File: rtl/p_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : p_fetch_ctrl_pkg
//  Brief    : Shared pipeline types and constants for the fetch sequencer.
//  Revision : 1.0
// ============================================================================
package p_fetch_ctrl_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_KILL = 2'd3
    } fetch_state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage
`default_nettype wire

// File: rtl/p_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : p_fetch_ctrl_if
//  Brief    : Instruction-memory request/response bus (one request in flight).
//  Revision : 1.0
// ============================================================================
interface p_fetch_ctrl_if;
    import p_fetch_ctrl_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, addr,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr,
        output gnt, rvalid, rdata
    );

endinterface
`default_nettype wire

// File: rtl/p_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : p_fetch_ctrl
//  Brief    : Fetch sequencer - PC, imem handshake, redirects, stalls, IF/ID feed.
//  Revision : 1.0
// ============================================================================
module p_fetch_ctrl
    import p_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned     BOOT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [XLEN-1:0]   i_redirect_pc,
    p_fetch_ctrl_if.master    imem,
    output logic              o_if_valid,
    output logic [XLEN-1:0]   o_inst,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_pc_plus_4,
    output logic              o_ifid_en,
    output logic              o_ifid_flush
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t    state_q;
    logic [3:0]      boot_cnt_q;
    logic [XLEN-1:0] pc_q;
    logic            if_valid_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_out_q;
    logic [XLEN-1:0] pc_plus4_q;

    logic slot_free;
    logic req;
    logic granted;
    logic flush;
    logic capture;
    logic consume;

    // A request may only go out if its response has somewhere to land.
    assign slot_free = ~if_valid_q | ~i_stall;
    assign req       = (state_q == ST_REQ) & slot_free;
    assign granted   = req & imem.gnt;
    assign flush     = i_redirect & (state_q != ST_BOOT);
    assign capture   = (state_q == ST_WAIT) & imem.rvalid & ~i_redirect;
    assign consume   = if_valid_q & ~i_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 4'd0;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            inst_q     <= INST_NOP;
            pc_out_q   <= '0;
            pc_plus4_q <= XLEN'(4);
        end else begin
            if (flush) begin
                if_valid_q <= 1'b0;
            end else if (capture) begin
                if_valid_q <= 1'b1;
                inst_q     <= imem.rdata;
                pc_out_q   <= pc_q;
                pc_plus4_q <= pc_q + XLEN'(4);
            end else if (consume) begin
                if_valid_q <= 1'b0;
            end

            if (flush) begin
                pc_q <= word_align(i_redirect_pc);
            end else if (capture) begin
                pc_q <= pc_q + XLEN'(4);
            end

            case (state_q)
                ST_BOOT: begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_q <= ST_REQ;
                    end else begin
                        boot_cnt_q <= boot_cnt_q + 4'd1;
                    end
                end
                ST_REQ: begin
                    if (granted) begin
                        state_q <= i_redirect ? ST_KILL : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        state_q <= ST_REQ;
                    end else if (i_redirect) begin
                        state_q <= ST_KILL;
                    end
                end
                // The stale response retires KILL even if another redirect lands with it.
                ST_KILL: begin
                    if (imem.rvalid) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    assign imem.req     = req;
    assign imem.addr    = pc_q;
    assign o_if_valid   = if_valid_q;
    assign o_inst       = inst_q;
    assign o_pc         = pc_out_q;
    assign o_pc_plus_4  = pc_plus4_q;
    assign o_ifid_en    = if_valid_q & ~i_stall;
    assign o_ifid_flush = flush;

    a_no_rvalid_in_req: assert property (
        @(posedge clk) disable iff (!rst_n) !((state_q == ST_REQ) && imem.rvalid)
    );

endmodule
`default_nettype wire

// File: tb/tb_p_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_p_fetch_ctrl
//  Brief    : Random stimulus for p_fetch_ctrl, instruction-stream scoreboard.
//  Revision : 1.0
// ============================================================================
module tb_p_fetch_ctrl;
    import p_fetch_ctrl_pkg::*;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          BOOT_CYCLES = 2;
    localparam int          NCYC        = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        ifid_en;
    logic        ifid_flush;
    logic        done;

    p_fetch_ctrl_if bus ();

    p_fetch_ctrl #(
        .RESET_PC    (RESET_PC),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .imem          (bus.master),
        .o_if_valid    (if_valid),
        .o_inst        (inst),
        .o_pc          (pc),
        .o_pc_plus_4   (pc4),
        .o_ifid_en     (ifid_en),
        .o_ifid_flush  (ifid_flush)
    );

    always #5 clk = ~clk;

    // Memory contents: every word is a fixed function of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'h0000_0103;
            3:       return 32'hFFFF_FFFC;
            4:       return 32'hFFFF_FFF8;
            default: return r;
        endcase
    endfunction

    // ---------------- stimulus + memory slave ----------------
    int          kd;
    int          rst_left;
    logic        s_busy;
    int          s_cnt;
    logic [31:0] s_addr;

    initial begin
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; done = 1'b0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        s_busy = 1'b0; s_cnt = 0; s_addr = '0; kd = 0; rst_left = 3;
        #1 rst_n = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (rst_n && bus.req && bus.gnt) begin
                s_busy = 1'b1;
                s_cnt  = $urandom_range(1, 3);
                s_addr = bus.addr;
            end
            @(posedge clk);
            #1;
            bus.rvalid = 1'b0;
            bus.rdata  = $urandom;
            if (s_busy) begin
                s_cnt--;
                if (s_cnt == 0) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = mem_word(s_addr);
                    s_busy     = 1'b0;
                end
            end
            redirect = 1'b0;
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) begin
                    rst_n = 1'b1;
                    kd    = 0;
                end
            end
            if (rst_n) begin
                stall   = ($urandom_range(0, 99) < 30);
                bus.gnt = ($urandom_range(0, 99) < 70);
                if (cyc == 1200 || cyc == 2400) begin
                    // Short reset lets a stale response land during BOOT.
                    #2 rst_n = 1'b0;
                    rst_left = (cyc == 1200) ? 1 : 3;
                end else if (kd == 1) begin
                    redirect    = 1'b1;
                    redirect_pc = 32'h0000_0400;
                end else if (kd >= BOOT_CYCLES && $urandom_range(0, 99) < 6) begin
                    redirect    = 1'b1;
                    redirect_pc = pick_target();
                end
                kd++;
            end
        end
        done = 1'b1;
    end

    // ---------------- reference model + scoreboard ----------------
    int          vectors = 0;
    int          miscompares = 0;
    int          consumed = 0;
    int          km = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_tail;
    logic        pend_v = 1'b0;
    logic [31:0] pend_addr;
    logic        hold_v = 1'b0;
    logic [31:0] hold_addr;
    logic        mon_out = 1'b0;
    logic        exp_flush;
    logic [31:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] start);
        exp_q.delete();
        exp_tail = start;
    endtask

    always @(negedge clk) begin
        if (done) begin
            check("throughput", 32'(consumed >= 150), 32'd1);
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
        if (rst_n && bus.req && bus.gnt) begin
            check("single_outstanding", 32'(mon_out), 32'd0);
            mon_out = 1'b1;
        end else if (bus.rvalid) begin
            mon_out = 1'b0;
        end

        if (!rst_n) begin
            check("rst_valid", 32'(if_valid), 32'd0);
            check("rst_inst", inst, INST_NOP);
            check("rst_pc", pc, 32'd0);
            check("rst_pc4", pc4, 32'd4);
            check("rst_req", 32'(bus.req), 32'd0);
            check("rst_addr", bus.addr, RESET_PC);
            km = 0;
            restart(RESET_PC);
            pend_v = 1'b0;
            hold_v = 1'b0;
        end else begin
            exp_flush = redirect && (km >= BOOT_CYCLES);
            check("ifid_en", 32'(ifid_en), 32'(if_valid & ~stall));
            check("ifid_flush", 32'(ifid_flush), 32'(exp_flush));
            if (km < BOOT_CYCLES) begin
                check("boot_req", 32'(bus.req), 32'd0);
            end else if (km == BOOT_CYCLES) begin
                check("first_req", 32'(bus.req), 32'd1);
                check("first_addr", bus.addr, RESET_PC);
            end
            if (km < BOOT_CYCLES + 2) check("early_valid", 32'(if_valid), 32'd0);
            if (if_valid && stall) check("stall_blocks_req", 32'(bus.req), 32'd0);
            if (if_valid) check("pc_plus_4", pc4, pc + 32'd4);
            if (bus.req) begin
                check("addr_align", 32'(bus.addr[1:0]), 32'd0);
                if (pend_v) begin
                    check("redirect_addr", bus.addr, pend_addr);
                    pend_v = 1'b0;
                end
                if (hold_v) check("addr_hold", bus.addr, hold_addr);
            end
            hold_v    = bus.req && !bus.gnt && !exp_flush;
            hold_addr = bus.addr;

            while (exp_q.size() < 8) begin
                exp_q.push_back(exp_tail);
                exp_tail = exp_tail + 32'd4;
            end
            if (if_valid && !stall && !exp_flush) begin
                e = exp_q.pop_front();
                check("fetch_pc", pc, e);
                check("fetch_inst", inst, mem_word(e));
                consumed++;
            end
            if (exp_flush) begin
                restart(redirect_pc & 32'hFFFF_FFFC);
                pend_v    = 1'b1;
                pend_addr = redirect_pc & 32'hFFFF_FFFC;
            end
            km++;
        end
    end

endmodule
`default_nettype wire
